// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// PC increment and the default reset PC.
package ifu_pkg;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  typedef enum logic [1:0] {
    BOOT  = ST_BOOT,
    FETCH = ST_FETCH,
    STALL = ST_STALL,
    HALT  = ST_HALT
  } fetch_state_e;

  localparam int unsigned PC_INC = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifid_pipe_reg.sv
// IF/ID holding register with valid/ready handshake and flush; keeps the
// instruction word and its PC+4 until decode accepts it.
module ifid_pipe_reg #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              capture,
  input  logic              ready,
  input  logic [DATA_W-1:0] instr_d,
  input  logic [ADDR_W-1:0] pc4_d,
  output logic [DATA_W-1:0] instr_q,
  output logic [ADDR_W-1:0] pc4_q,
  output logic              valid_q
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= 1'b1;
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: PC register and fetch FSM feeding the IF/ID register.
// Optional performance counters are enabled with `define IFU_PERF_CNT_EN.
module fetch_sequencer
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Instruction,
  output logic [DATA_W-1:0] InstrOut,
  output logic [ADDR_W-1:0] PCPlus4Out,
  output logic              Valid,
  input  logic              Ready,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] Target,
  input  logic              Halt,
  output logic              Halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       FetchCount,
  output logic [31:0]       StallCount
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target_aligned;
  logic              load;
  logic              capture;

  assign pc_inc         = pc_q + ADDR_W'(PC_INC);
  assign target_aligned = Target & ~ADDR_W'(3);
  assign load           = !Valid || Ready;
  assign Address        = pc_q;
  assign Halted         = (state_q == HALT);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    if (Redirect) begin
      pc_d    = target_aligned;
      state_d = FETCH;
    end else begin
      case (state_q)
        BOOT:  state_d = FETCH;
        FETCH,
        STALL: begin
          if (Halt) begin
            state_d = HALT;
          end else if (load) begin
            capture = 1'b1;
            pc_d    = pc_inc;
            state_d = FETCH;
          end else begin
            state_d = STALL;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = BOOT;
      endcase
    end
  end

  // A redirect flushes the held word, so a simultaneous Ready is not a transfer.
  ifid_pipe_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ifid (
    .clk     (Clk),
    .reset   (Reset),
    .flush   (Redirect),
    .capture (capture),
    .ready   (Ready),
    .instr_d (Instruction),
    .pc4_d   (pc_inc),
    .instr_q (InstrOut),
    .pc4_q   (PCPlus4Out),
    .valid_q (Valid)
  );

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else begin
      if (Valid && Ready && !Redirect) FetchCount <= FetchCount + 32'd1;
      if (Valid && !Ready)             StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic [31:0] InstrOut;
  logic [31:0] PCPlus4Out;
  logic        Valid;
  logic        Ready;
  logic        Redirect;
  logic [31:0] Target;
  logic        Halt;
  logic        Halted;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
`endif

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  logic [31:0] m_pc, m_instr, m_pc4, m_fcnt, m_scnt;
  logic        m_valid, m_boot, m_halted;
  logic        chk_en = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'(a[8:2]) * 32'd3;
  endfunction

  assign Instruction = mem_word(Address);

  always #5 Clk = ~Clk;

  fetch_sequencer #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (RST_PC)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Address     (Address),
    .Instruction (Instruction),
    .InstrOut    (InstrOut),
    .PCPlus4Out  (PCPlus4Out),
    .Valid       (Valid),
    .Ready       (Ready),
    .Redirect    (Redirect),
    .Target      (Target),
    .Halt        (Halt),
    .Halted      (Halted)
`ifdef IFU_PERF_CNT_EN
    ,
    .FetchCount  (FetchCount),
    .StallCount  (StallCount)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
    m_boot = 1'b1; m_halted = 1'b0; m_fcnt = '0; m_scnt = '0;
  endtask

  // One clock of the fetch rules, evaluated from the inputs seen at the edge.
  task automatic model_step();
    if (m_valid && Ready && !Redirect) m_fcnt = m_fcnt + 1;
    if (m_valid && !Ready)             m_scnt = m_scnt + 1;
    if (Redirect) begin
      m_pc = Target & ~32'h3; m_valid = 1'b0; m_boot = 1'b0; m_halted = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halted || Halt) begin
      m_halted = 1'b1;
      if (m_valid && Ready) m_valid = 1'b0;
    end else if (!m_valid || Ready) begin
      m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      check("address", Address, m_pc);
      check("valid", 32'(Valid), 32'(m_valid));
      check("halted", 32'(Halted), 32'(m_halted));
      if (m_valid) begin
        check("instr_out", InstrOut, m_instr);
        check("pc_plus4_out", PCPlus4Out, m_pc4);
      end
`ifdef IFU_PERF_CNT_EN
      check("fetch_count", FetchCount, m_fcnt);
      check("stall_count", StallCount, m_scnt);
`endif
    end
  end

  task automatic do_reset();
    chk_en = 1'b0;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    model_reset();
    Reset = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    Reset = 1'b1; Ready = 1'b0; Redirect = 1'b0; Target = '0; Halt = 1'b0;
    model_reset();
    repeat (2) @(negedge Clk);
    check("reset_valid", 32'(Valid), 32'd0);
    check("reset_instr", InstrOut, 32'd0);
    check("reset_pc4", PCPlus4Out, 32'd0);
    check("reset_halted", 32'(Halted), 32'd0);
    check("reset_address", Address, RST_PC);
    do_reset();

    // streaming
    Ready = 1'b1;
    tick();
    check("boot_no_capture", 32'(Valid), 32'd0);
    tick();
    check("first_instr", InstrOut, 32'd0);
    check("first_pc4", PCPlus4Out, 32'd4);
    tick(); check("stream_instr1", InstrOut, 32'd3);
    tick(); check("stream_instr2", InstrOut, 32'd6);

    // stall with word 6 held
    Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_instr", InstrOut, 32'd6);
      check("stall_address", Address, 32'h0C);
    end
    Ready = 1'b1;
    tick(); check("stall_release", InstrOut, 32'd9);
    check("stall_release_valid", 32'(Valid), 32'd1);

    // redirect with simultaneous ready
    Redirect = 1'b1; Target = 32'h43;
    tick();
    check("redirect_valid", 32'(Valid), 32'd0);
    check("redirect_address", Address, 32'h40);
    Redirect = 1'b0;
    tick();
    check("redirect_instr", InstrOut, 32'd48);
    check("redirect_pc4", PCPlus4Out, 32'h44);

    // halt while holding a word
    Ready = 1'b0; Halt = 1'b1;
    tick();
    check("halt_flag", 32'(Halted), 32'd1);
    check("halt_held_instr", InstrOut, 32'd48);
    check("halt_held_valid", 32'(Valid), 32'd1);
    Halt = 1'b0; Ready = 1'b1;
    tick();
    check("halt_drained", 32'(Valid), 32'd0);
    tick();
    check("halt_pc_frozen", Address, 32'h44);
    Halt = 1'b1;
    Redirect = 1'b1; Target = 32'h10;
    tick();
    check("halt_exit", 32'(Halted), 32'd0);
    Redirect = 1'b0; Halt = 1'b0;
    tick();
    check("resume_instr", InstrOut, 32'd12);

    // PC wrap
    Redirect = 1'b1; Target = 32'hFFFF_FFFC;
    tick();
    Redirect = 1'b0;
    tick();
    check("wrap_pc4", PCPlus4Out, 32'd0);
    check("wrap_instr", InstrOut, 32'd381);
    check("wrap_address", Address, 32'd0);
    tick();
    check("wrap_next_instr", InstrOut, 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      Ready    = ($urandom_range(0, 9) < 7);
      Redirect = ($urandom_range(0, 19) == 0);
      Halt     = ($urandom_range(0, 24) == 0);
      Target   = $urandom;
      tick();
    end

    // async reset in the middle of a stall
    Halt = 1'b0; Redirect = 1'b1; Target = 32'h100; Ready = 1'b1;
    tick();
    Redirect = 1'b0;
    tick();
    Ready = 1'b0;
    tick(); tick();
    check("pre_reset_valid", 32'(Valid), 32'd1);
    chk_en = 1'b0;
    #2 Reset = 1'b1;
    #1;
    check("async_reset_valid", 32'(Valid), 32'd0);
    check("async_reset_address", Address, RST_PC);
    check("async_reset_instr", InstrOut, 32'd0);
`ifdef IFU_PERF_CNT_EN
    check("async_reset_fetch_count", FetchCount, 32'd0);
    check("async_reset_stall_count", StallCount, 32'd0);
`endif
    @(negedge Clk);
    do_reset();
    for (int i = 0; i < 100; i++) begin
      Ready    = ($urandom_range(0, 3) != 0);
      Redirect = ($urandom_range(0, 15) == 0);
      Halt     = ($urandom_range(0, 30) == 0);
      Target   = $urandom;
      tick();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
